// File: rtl/cpu_pkg.sv
// Shared constants for the data-memory responder: MMIO map, target-select
// encoding, read FSM states and the request address decoder.
package cpu_pkg;

   localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
   localparam logic [31:0] OUT_REG_OFS = 32'd0;
   localparam logic [31:0] SW_REG_OFS  = 32'd4;

   typedef enum logic [1:0] {
      TGT_RAM  = 2'd0,
      TGT_OUT  = 2'd1,
      TGT_SW   = 2'd2,
      TGT_NONE = 2'd3
   } tgt_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_e;

   // Range check uses the full address, so nothing above the RAM aliases into it.
   function automatic tgt_e decode(input logic [31:0] addr,
                                   input int unsigned aw,
                                   input logic [31:0] base);
      logic [31:0] word_addr;
      word_addr = {addr[31:2], 2'b00};
      if ((addr >> (aw + 2)) == 32'd0)
         return TGT_RAM;
      else if (word_addr == base + OUT_REG_OFS)
         return TGT_OUT;
      else if (word_addr == base + SW_REG_OFS)
         return TGT_SW;
      else
         return TGT_NONE;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with registered read, written so that
// FPGA tools infer block RAM. Contents are intentionally not reset.
module dmem_ram #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           d,
   output logic [31:0]           q
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= d;
      q <= mem[addr];
   end

endmodule

// File: rtl/data_mem_rsp.sv
// Load/store responder: single-cycle writes, fixed two-cycle read latency
// from word RAM, display output register and synchronized switch inputs.
module data_mem_rsp #(
   parameter int          ADDR_WIDTH = 5,
   parameter logic [31:0] MMIO_BASE  = cpu_pkg::MMIO_BASE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   input  logic        rsp_ready,
   input  logic [15:0] sw_in,
   output logic [15:0] data_out
);

   import cpu_pkg::*;

   state_e      state_q;
   tgt_e        tgt_q;
   tgt_e        req_tgt;
   logic [31:0] rsp_rdata_q;
   logic [15:0] data_out_q;
   logic [15:0] data_out_d;
   logic [15:0] sw_meta_q;
   logic [15:0] sw_sync_q;
   logic [31:0] ram_q;
   logic [31:0] rd_mux;
   logic        accept;
   logic        ram_we;

   assign req_tgt   = decode(req_addr, ADDR_WIDTH, MMIO_BASE);
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign data_out  = data_out_q;
   assign accept    = req_valid & req_ready;
   assign ram_we    = accept & req_we & (req_tgt == TGT_RAM);

   dmem_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (req_addr[ADDR_WIDTH+1:2]),
      .d    (req_wdata),
      .q    (ram_q)
   );

   always_comb begin
      data_out_d = data_out_q;
      if (accept && req_we && (req_tgt == TGT_OUT))
         data_out_d = req_wdata[15:0];
   end

   always_comb begin
      rd_mux = 32'h0;
      case (tgt_q)
         TGT_RAM:  rd_mux = ram_q;
         TGT_OUT:  rd_mux = {16'h0, data_out_q};
         TGT_SW:   rd_mux = {16'h0, sw_sync_q};
         default:  rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= 16'h0;
         sw_meta_q  <= 16'h0;
         sw_sync_q  <= 16'h0;
      end else begin
         data_out_q <= data_out_d;
         sw_meta_q  <= sw_in;
         sw_sync_q  <= sw_meta_q;
      end
   end

   // The RAM q captured at the accept edge is valid throughout RD_WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tgt_q       <= TGT_NONE;
         rsp_rdata_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && !req_we) begin
                  tgt_q   <= req_tgt;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               rsp_rdata_q <= rd_mux;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
